// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register with a 2-entry skid buffer: one-cycle latency, full throughput,
// in_ready is a pure flop decode so back-pressure never chains combinationally. Optional stall counter via PIPE_STAGE_STATS_EN.
module pipe_stage_reg #(
  parameter int DATA_W = 71,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_count
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_fire;
  logic              out_fire;

  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = (state_q != ST_FULL);
  assign out_data  = main_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          main_d  = in_data;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire) begin
          skid_d  = in_data;
          state_d = ST_FULL;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only the drain case needs handling.
        if (out_fire) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush wins over any transfer; data registers keep their stale contents.
    if (flush) begin
      state_d = ST_EMPTY;
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && !out_ready && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_count = cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vector table, async-reset and stall-counter sequences, then a randomized queue-model scoreboard.
module tb_pipe_stage_reg;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
`ifdef PIPE_STAGE_STATS_EN
  logic [3:0]    stall_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W(DW),
    .CNT_W (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
`ifdef PIPE_STAGE_STATS_EN
    ,
    .stall_count(stall_count)
`endif
  );

  typedef struct {
    logic          iv;
    logic [DW-1:0] id;
    logic          ordy;
    logic          fl;
    logic          ov;
    logic          ir;
    logic [DW-1:0] od;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic iv, input logic [DW-1:0] id, input logic ordy,
                              input logic fl, input logic ov, input logic ir,
                              input logic [DW-1:0] od);
    vec_t v;
    v.iv = iv; v.id = id; v.ordy = ordy; v.fl = fl;
    v.ov = ov; v.ir = ir; v.od = od;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [DW-1:0] mq[$];
  int            m_stall;
  logic          m_in_fire, m_out_fire, m_stall_ev;
  logic          ir_a;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // stream, back-pressure/skid, flush in FULL, flush in ONE
    vecs[0]  = mk(1'b1, 8'h10, 1'b1, 1'b0, 1'b1, 1'b1, 8'h10);
    vecs[1]  = mk(1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11);
    vecs[2]  = mk(1'b1, 8'h12, 1'b1, 1'b0, 1'b1, 1'b1, 8'h12);
    vecs[3]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    vecs[4]  = mk(1'b1, 8'h0A, 1'b0, 1'b0, 1'b1, 1'b1, 8'h0A);
    vecs[5]  = mk(1'b1, 8'h0B, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0A);
    vecs[6]  = mk(1'b1, 8'h0C, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0A);
    vecs[7]  = mk(1'b1, 8'h0C, 1'b1, 1'b0, 1'b1, 1'b1, 8'h0B);
    vecs[8]  = mk(1'b1, 8'h0C, 1'b1, 1'b0, 1'b1, 1'b1, 8'h0C);
    vecs[9]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    vecs[10] = mk(1'b1, 8'h21, 1'b0, 1'b0, 1'b1, 1'b1, 8'h21);
    vecs[11] = mk(1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 8'h21);
    vecs[12] = mk(1'b1, 8'h0D, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    vecs[13] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    vecs[14] = mk(1'b1, 8'h31, 1'b1, 1'b0, 1'b1, 1'b1, 8'h31);
    vecs[15] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    vecs[16] = mk(1'b1, 8'h41, 1'b0, 1'b0, 1'b1, 1'b1, 8'h41);
    vecs[17] = mk(1'b1, 8'h42, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
    vecs[18] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);

    @(negedge clk);
    @(negedge clk);
    chk("reset out_valid", out_valid, 1'b0);
    chk("reset in_ready", in_ready, 1'b1);
    chk("reset out_data", out_data, 8'h00);
`ifdef PIPE_STAGE_STATS_EN
    chk("reset stall_count", stall_count, 4'd0);
`endif
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      in_valid = vecs[i].iv; in_data = vecs[i].id;
      out_ready = vecs[i].ordy; flush = vecs[i].fl;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d out_valid", i), out_valid, vecs[i].ov);
      chk($sformatf("vec%0d in_ready", i), in_ready, vecs[i].ir);
      if (vecs[i].ov) chk($sformatf("vec%0d out_data", i), out_data, vecs[i].od);
    end
    flush = 1'b0;

    // Asynchronous reset while holding one entry.
    in_valid = 1'b1; in_data = 8'h66; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre-arst out_valid", out_valid, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("arst out_valid", out_valid, 1'b0);
    chk("arst in_ready", in_ready, 1'b1);
    chk("arst out_data", out_data, 8'h00);
    #1 rst = 1'b0;
    in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("post-arst out_valid", out_valid, 1'b1);
    chk("post-arst out_data", out_data, 8'h55);
    @(posedge clk);
    @(negedge clk);
    chk("post-arst drain", out_valid, 1'b0);

`ifdef PIPE_STAGE_STATS_EN
    do_reset();
    chk("stall start", stall_count, 4'd0);
    in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("stall after load", stall_count, 4'd0);
    repeat (5) @(negedge clk);
    chk("stall 5", stall_count, 4'd5);
    repeat (15) @(negedge clk);
    chk("stall saturated", stall_count, 4'd15);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("stall after flush", stall_count, 4'd15);
    chk("flush out_valid", out_valid, 1'b0);
`endif

    // Randomized run against a queue model.
    do_reset();
    mq.delete();
    m_stall = 0;
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      in_data   = DW'($urandom);
      out_ready = ($urandom_range(0, 99) < (((c / 1000) % 2 == 0) ? 80 : 30));
      flush     = ($urandom_range(0, 63) == 0);
      #1 ir_a = in_ready;
      if ($urandom_range(0, 1) == 1) out_ready = ~out_ready;
      #1 chk("in_ready mid-cycle", in_ready, ir_a);
      m_in_fire  = in_valid && (mq.size() < 2);
      m_out_fire = out_ready && (mq.size() > 0);
      m_stall_ev = (mq.size() > 0) && !out_ready;
      @(posedge clk);
      if (flush) begin
        mq.delete();
      end else begin
        if (m_out_fire) void'(mq.pop_front());
        if (m_in_fire) mq.push_back(in_data);
      end
      if (m_stall_ev && m_stall < 15) m_stall++;
      @(negedge clk);
      chk("rand out_valid", out_valid, (mq.size() != 0));
      chk("rand in_ready", in_ready, (mq.size() < 2));
      if (mq.size() > 0) chk("rand out_data", out_data, mq[0]);
`ifdef PIPE_STAGE_STATS_EN
      chk("rand stall_count", stall_count, m_stall);
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
